ex_hazard_ctrl: RTL and testbench

//  Consumer-side control for the ID/EX pipeline register: decides each cycle whether ID/EX

---
 rtl/mips_pipe_pkg.sv | 19 +
 rtl/ex_hazard_ctrl_fwd_match.sv | 32 +++
 rtl/ex_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline control slice: hazard FSM states and
// operand-forwarding select encodings.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/ex_hazard_ctrl_fwd_match.sv
// Next forwarding select for one EX operand, chosen in ID from the EX and MEM
// stage producers; the newer (EX) producer wins.
import mips_pipe_pkg::*;

module fwd_match #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_reg,
    input  logic             use_src,
    input  logic             ex_wr_en,
    input  logic [REG_W-1:0] ex_wr_num,
    input  logic             mem_wr_en,
    input  logic [REG_W-1:0] mem_wr_num,
    input  logic             load_use,
    output fwd_sel_e         fwd_sel
);

    logic src_live_s;

    // A loaded value is not ready in EX/MEM, so a load-use match never selects EX/MEM.
    always_comb begin
        src_live_s = use_src && (src_reg != REG_W'(REG_ZERO));
        if (src_live_s && ex_wr_en && (ex_wr_num == src_reg) && !load_use) begin
            fwd_sel = FWD_EXMEM;
        end else if (src_live_s && mem_wr_en && (mem_wr_num == src_reg)) begin
            fwd_sel = FWD_MEMWB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ID/EX consumer-side hazard control: load-use stalls, branch flushes, data-memory
// freezes, registered forwarding selects and saturating stall/flush counters.
import mips_pipe_pkg::*;

module ex_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             wr_en_reg_id_ex,
    input  logic [REG_W-1:0] wr_num_id_ex,
    input  logic             mem_rd_id_ex,
    input  logic             wr_en_reg_ex_mem,
    input  logic [REG_W-1:0] wr_num_ex_mem,
    input  logic             branch_taken_ex,
    input  logic             dm_busy,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             freeze_all,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e        state_r, state_nxt_s;
    fwd_sel_e         fwd_a_nxt_s, fwd_b_nxt_s;
    fwd_sel_e         fwd_a_r, fwd_b_r;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic             load_use_s;
    logic             stall_s, flush_s, bubble_s, freeze_s;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use_s = mem_rd_id_ex && wr_en_reg_id_ex &&
                     (wr_num_id_ex != REG_W'(REG_ZERO)) &&
                     ((use_rs_id && (rs_id == wr_num_id_ex)) ||
                      (use_rt_id && (rt_id == wr_num_id_ex)));
    end

    fwd_match #(.REG_W(REG_W)) u_fwd_a (
        .src_reg    (rs_id),
        .use_src    (use_rs_id),
        .ex_wr_en   (wr_en_reg_id_ex),
        .ex_wr_num  (wr_num_id_ex),
        .mem_wr_en  (wr_en_reg_ex_mem),
        .mem_wr_num (wr_num_ex_mem),
        .load_use   (load_use_s),
        .fwd_sel    (fwd_a_nxt_s)
    );

    fwd_match #(.REG_W(REG_W)) u_fwd_b (
        .src_reg    (rt_id),
        .use_src    (use_rt_id),
        .ex_wr_en   (wr_en_reg_id_ex),
        .ex_wr_num  (wr_num_id_ex),
        .mem_wr_en  (wr_en_reg_ex_mem),
        .mem_wr_num (wr_num_ex_mem),
        .load_use   (load_use_s),
        .fwd_sel    (fwd_b_nxt_s)
    );

    // Prioritised pipeline controls; LD_STALL never re-inserts a bubble for the same load.
    always_comb begin
        stall_s  = 1'b0;
        flush_s  = 1'b0;
        bubble_s = 1'b0;
        freeze_s = 1'b0;
        if (dm_busy) begin
            freeze_s = 1'b1;
        end else if (branch_taken_ex) begin
            flush_s  = 1'b1;
            bubble_s = 1'b1;
        end else if ((state_r == RUN) && load_use_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
        end else begin
            stall_s  = 1'b0;
        end
    end

    // Hazard FSM next-state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (dm_busy) begin
                    state_nxt_s = MEM_WAIT;
                end else if (load_use_s && !branch_taken_ex) begin
                    state_nxt_s = LD_STALL;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LD_STALL: state_nxt_s = dm_busy ? MEM_WAIT : RUN;
            MEM_WAIT: state_nxt_s = dm_busy ? MEM_WAIT : RUN;
            default:  state_nxt_s = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Forwarding selects travel with their instruction into EX; a bubble carries no forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_r <= FWD_RF;
            fwd_b_r <= FWD_RF;
        end else if (freeze_s) begin
            fwd_a_r <= fwd_a_r;
            fwd_b_r <= fwd_b_r;
        end else if (bubble_s) begin
            fwd_a_r <= FWD_RF;
            fwd_b_r <= FWD_RF;
        end else begin
            fwd_a_r <= fwd_a_nxt_s;
            fwd_b_r <= fwd_b_nxt_s;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((stall_s || freeze_s) && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign stall_if_id  = stall_s;
    assign flush_if_id  = flush_s;
    assign bubble_id_ex = bubble_s;
    assign freeze_all   = freeze_s;
    assign fwd_a_sel    = fwd_a_r;
    assign fwd_b_sel    = fwd_b_r;
    assign stall_cnt    = stall_cnt_r;
    assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed-vector bench for ex_hazard_ctrl with immediate-assertion checks.
import mips_pipe_pkg::*;

module tb_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  rs_id, rt_id, wr_num_id_ex, wr_num_ex_mem;
    logic        use_rs_id, use_rt_id, wr_en_reg_id_ex, mem_rd_id_ex;
    logic        wr_en_reg_ex_mem, branch_taken_ex, dm_busy;
    logic        stall_if_id, flush_if_id, bubble_id_ex, freeze_all;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    ex_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .wr_en_reg_id_ex(wr_en_reg_id_ex), .wr_num_id_ex(wr_num_id_ex),
        .mem_rd_id_ex(mem_rd_id_ex), .wr_en_reg_ex_mem(wr_en_reg_ex_mem),
        .wr_num_ex_mem(wr_num_ex_mem), .branch_taken_ex(branch_taken_ex),
        .dm_busy(dm_busy), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .bubble_id_ex(bubble_id_ex), .freeze_all(freeze_all),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic st, input logic fl,
                       input logic bu, input logic fz);
        chk({tag, "_stall"},  {31'd0, stall_if_id},  {31'd0, st});
        chk({tag, "_flush"},  {31'd0, flush_if_id},  {31'd0, fl});
        chk({tag, "_bubble"}, {31'd0, bubble_id_ex}, {31'd0, bu});
        chk({tag, "_freeze"}, {31'd0, freeze_all},   {31'd0, fz});
    endtask

    task automatic idle();
        rs_id = 5'd0; rt_id = 5'd0; use_rs_id = 1'b0; use_rt_id = 1'b0;
        wr_en_reg_id_ex = 1'b0; wr_num_id_ex = 5'd0; mem_rd_id_ex = 1'b0;
        wr_en_reg_ex_mem = 1'b0; wr_num_ex_mem = 5'd0;
        branch_taken_ex = 1'b0; dm_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
        chk("rst_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        chk("rst_state", {30'd0, dut.state_r}, {30'd0, RUN});
        ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: add $3 in EX, ID reads rs=$3
        idle(); wr_en_reg_id_ex = 1'b1; wr_num_id_ex = 5'd3; rs_id = 5'd3; use_rs_id = 1'b1;
        #1 ctl("t1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t1_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
        chk("t1_fwd_b", {30'd0, fwd_b_sel}, 32'd0);

        // 2: add $3 in MEM, sub $3 in EX, ID reads rt=$3
        idle(); wr_en_reg_id_ex = 1'b1; wr_num_id_ex = 5'd3;
        wr_en_reg_ex_mem = 1'b1; wr_num_ex_mem = 5'd3; rt_id = 5'd3; use_rt_id = 1'b1;
        tick();
        chk("t2_fwd_b", {30'd0, fwd_b_sel}, 32'd1);
        chk("t2_fwd_a", {30'd0, fwd_a_sel}, 32'd0);

        // 2b: only MEM producer
        idle(); wr_en_reg_ex_mem = 1'b1; wr_num_ex_mem = 5'd7; rs_id = 5'd7; use_rs_id = 1'b1;
        tick();
        chk("t2b_fwd_a", {30'd0, fwd_a_sel}, 32'd2);

        // 3: lw $5 in EX, ID reads rt=$5
        idle(); mem_rd_id_ex = 1'b1; wr_en_reg_id_ex = 1'b1; wr_num_id_ex = 5'd5;
        rt_id = 5'd5; use_rt_id = 1'b1;
        #1 ctl("t3_lu", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("t3_state_ld", {30'd0, dut.state_r}, {30'd0, LD_STALL});
        chk("t3_fwd_b_bub", {30'd0, fwd_b_sel}, 32'd0);
        chk("t3_cnt1", {16'd0, stall_cnt}, 32'd1);
        idle(); wr_en_reg_ex_mem = 1'b1; wr_num_ex_mem = 5'd5; rt_id = 5'd5; use_rt_id = 1'b1;
        #1 ctl("t3_ld", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t3_state_run", {30'd0, dut.state_r}, {30'd0, RUN});
        chk("t3_fwd_b", {30'd0, fwd_b_sel}, 32'd2);
        chk("t3_cnt", {16'd0, stall_cnt}, 32'd1);

        // 4: load-use plus taken branch
        idle(); mem_rd_id_ex = 1'b1; wr_en_reg_id_ex = 1'b1; wr_num_id_ex = 5'd5;
        rt_id = 5'd5; use_rt_id = 1'b1; branch_taken_ex = 1'b1;
        #1 ctl("t4", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t4_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("t4_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        chk("t4_state", {30'd0, dut.state_r}, {30'd0, RUN});

        // 5: dm_busy for 3 cycles during LD_STALL
        idle();
        do_reset();
        mem_rd_id_ex = 1'b1; wr_en_reg_id_ex = 1'b1; wr_num_id_ex = 5'd5;
        rt_id = 5'd5; use_rt_id = 1'b1;
        #1 ctl("t5_lu", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle(); dm_busy = 1'b1; wr_en_reg_id_ex = 1'b1; wr_num_id_ex = 5'd3;
        rs_id = 5'd3; use_rs_id = 1'b1; branch_taken_ex = 1'b1;
        #1 ctl("t5_fz", 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        chk("t5_hold_a", {30'd0, fwd_a_sel}, 32'd0);
        chk("t5_state_mw", {30'd0, dut.state_r}, {30'd0, MEM_WAIT});
        chk("t5_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        dm_busy = 1'b0; branch_taken_ex = 1'b0;
        #1 ctl("t5_rel", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t5_state_run", {30'd0, dut.state_r}, {30'd0, RUN});
        chk("t5_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
        chk("t5_cnt", {16'd0, stall_cnt}, 32'd4);

        // 6: dependency on $0
        idle(); mem_rd_id_ex = 1'b1; wr_en_reg_id_ex = 1'b1; wr_num_id_ex = 5'd0;
        wr_en_reg_ex_mem = 1'b1; wr_num_ex_mem = 5'd0; use_rs_id = 1'b1; use_rt_id = 1'b1;
        #1 ctl("t6", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t6_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
        chk("t6_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
        chk("t6_cnt", {16'd0, stall_cnt}, 32'd4);

        // Saturation: freeze long enough to reach all-ones, then keep stalling
        idle(); dm_busy = 1'b1;
        repeat (65531) tick();
        chk("sat_reach", {16'd0, stall_cnt}, 32'h0000_ffff);
        repeat (2) tick();
        chk("sat_hold", {16'd0, stall_cnt}, 32'h0000_ffff);
        chk("sat_state", {30'd0, dut.state_r}, {30'd0, MEM_WAIT});

        // Async reset mid MEM_WAIT, away from a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", {30'd0, dut.state_r}, {30'd0, RUN});
        chk("ar_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("ar_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        dm_busy = 1'b0;
        #1 ctl("ar", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
